// File: rtl/i2c_target_rx_if.sv
// i2c_target_rx_if
//   Bus and receive-stream signals of the write-only I2C target receiver.
//   slave  : the receiver itself (samples SCL/SDA_IN, drives the stream).
//   master : the bus/consumer side (bus driver plus stream consumer).
//   Signals:
//     SCL, SDA_IN  I2C lines as seen on the wire (asynchronous)
//     sda_pull     1 = target pulls SDA low
//     rx_data      byte at the FIFO head
//     rx_first     head byte is the first data byte after the address
//     rx_valid     FIFO not empty
//     rx_ready     consumer accepts the head byte
//     busy         addressed transaction in progress
//     overflow     sticky: a byte was NACKed because the FIFO was full
interface i2c_target_rx_if;
  logic       SCL;
  logic       SDA_IN;
  logic       sda_pull;
  logic [7:0] rx_data;
  logic       rx_first;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       overflow;

  modport slave (
    input  SCL, SDA_IN, rx_ready,
    output sda_pull, rx_data, rx_first, rx_valid, busy, overflow
  );

  modport master (
    output SCL, SDA_IN, rx_ready,
    input  sda_pull, rx_data, rx_first, rx_valid, busy, overflow
  );
endinterface

// File: rtl/i2c_target_rx.sv
// i2c_target_rx
//   Write-only I2C target. Matches a 7-bit address, ACKs writes and pushes
//   each received byte (tagged with a "first data byte" flag) into a
//   first-word-fall-through FIFO read out over a valid/ready stream.
//   Ports:
//     clk      system clock, SCL/SDA sampled on its rising edge
//     n_reset  asynchronous active-low reset
//     bus      i2c_target_rx_if.slave (I2C lines + receive stream)
//   Optional build macro:
//     I2C_TARGET_GLITCH_FILTER_EN  adds a 3-sample majority filter on both
//                                  lines after synchronization.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   ST_IDLE     | bus idle or not ours, waiting for START
//   ST_ADDR     | shifting the address byte
//   ST_ADDR_ACK | pulling SDA for the address ACK
//   ST_DATA     | shifting a data byte
//   ST_DATA_ACK | pulling SDA for the data ACK
//   ST_IGNORE   | not addressed / NACKed, waiting for START or STOP
module i2c_target_rx #(
  parameter logic [6:0] ADDRESS    = 7'h3C,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           n_reset,
  i2c_target_rx_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK, ST_IGNORE
  } state_t;

  // Synchronizers reset to 1 so leaving reset looks like an idle bus.
  logic [1:0] r_scl_sync, r_sda_sync;
  logic       r_scl_prev, r_sda_prev;
  logic       w_s_scl, w_s_sda;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], bus.SCL};
      r_sda_sync <= {r_sda_sync[0], bus.SDA_IN};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  // Majority of the current and two previous synchronized samples.
  logic [1:0] r_scl_hist, r_sda_hist;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
    end
  end

  assign w_s_scl = (r_scl_sync[1] & r_scl_hist[0]) | (r_scl_sync[1] & r_scl_hist[1]) |
                   (r_scl_hist[0] & r_scl_hist[1]);
  assign w_s_sda = (r_sda_sync[1] & r_sda_hist[0]) | (r_sda_sync[1] & r_sda_hist[1]) |
                   (r_sda_hist[0] & r_sda_hist[1]);
`else
  assign w_s_scl = r_scl_sync[1];
  assign w_s_sda = r_sda_sync[1];
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_s_scl;
      r_sda_prev <= w_s_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_s_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_s_scl & r_scl_prev;
  assign w_start    = w_s_scl & r_sda_prev & ~w_s_sda;
  assign w_stop     = w_s_scl & ~r_sda_prev & w_s_sda;

  state_t     r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_first;
  logic       r_sda_pull;
  logic       r_busy;
  logic       r_overflow;

  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full, w_valid, w_byte_done, w_push, w_pop, w_ovf_set;
  assign w_full      = (r_count == DEPTH_C);
  assign w_valid     = (r_count != '0);
  // START/STOP outrank the bit edge that completes a byte.
  assign w_byte_done = (r_state == ST_DATA) && w_scl_fall && (r_bit_cnt == 4'd8) &&
                       !w_start && !w_stop;
  assign w_push      = w_byte_done && !w_full;
  assign w_ovf_set   = w_byte_done && w_full;
  assign w_pop       = w_valid && bus.rx_ready;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'h00;
      r_first    <= 1'b0;
      r_sda_pull <= 1'b0;
      r_busy     <= 1'b0;
    end else if (w_start) begin
      r_state    <= ST_ADDR;
      r_bit_cnt  <= 4'd0;
      r_sda_pull <= 1'b0;
      r_busy     <= 1'b0;
    end else if (w_stop) begin
      r_state    <= ST_IDLE;
      r_sda_pull <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_DATA: begin
          if (w_scl_rise) begin
            r_shift   <= {r_shift[6:0], w_s_sda};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            if (r_state == ST_ADDR) begin
              if (r_shift[7:1] == ADDRESS && !r_shift[0]) begin
                r_state    <= ST_ADDR_ACK;
                r_sda_pull <= 1'b1;
                r_busy     <= 1'b1;
              end else begin
                r_state <= ST_IGNORE;
              end
            end else if (!w_full) begin
              r_state    <= ST_DATA_ACK;
              r_sda_pull <= 1'b1;
              r_first    <= 1'b0;
            end else begin
              r_state <= ST_IGNORE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (w_scl_fall) begin
            if (r_state == ST_ADDR_ACK) r_first <= 1'b1;
            r_state    <= ST_DATA;
            r_sda_pull <= 1'b0;
            r_bit_cnt  <= 4'd0;
          end
        end
        ST_IDLE, ST_IGNORE: ;
        default: begin
          r_state    <= ST_IDLE;
          r_sda_pull <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)       r_overflow <= 1'b0;
    else if (w_ovf_set) r_overflow <= 1'b1;
    else if (w_start)   r_overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_first, r_shift};
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  logic [8:0] w_head;
  assign w_head = r_mem[r_rd_ptr];

  assign bus.rx_valid = w_valid;
  assign bus.rx_data  = w_valid ? w_head[7:0] : 8'h00;
  assign bus.rx_first = w_valid ? w_head[8]   : 1'b0;
  assign bus.sda_pull = r_sda_pull;
  assign bus.busy     = r_busy;
  assign bus.overflow = r_overflow;

endmodule
